cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit_pkg.sv | 21 ++
 rtl/cp0_timer.sv | 47 ++++
 rtl/cp0_unit.sv | 103 ++++++++++
 tb/tb_cp0_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// CP0 shared constants: register numbers, exception codes, handler address.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'b01000;
    localparam logic [4:0] EXC_BREAK   = 5'b01001;
    localparam logic [4:0] EXC_TEQ     = 5'b01101;

    localparam logic [31:0] CP0_HANDLER_ADDR = 32'h0040_0004;

    // Cause[15] is the timer-interrupt pending bit; it is owned by the timer, not by mtc0.
    localparam logic [31:0] CAUSE_TI_MASK = 32'h0000_8000;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with sticky interrupt, cleared by a Compare write.
// Latency: registers update one cycle after the write or match.
// Backpressure: none; accepts a write every cycle.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        irq
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        irq_q, irq_d;

    always_comb begin
        count_d   = wr_count ? wdata : count_q + 32'd1;
        compare_d = wr_compare ? wdata : compare_q;
        irq_d     = irq_q;
        // A Compare write acknowledges the interrupt even if the match fires this cycle.
        if (wr_compare) begin
            irq_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign irq     = irq_q;

endmodule

// File: rtl/cp0_unit.sv
// CP0 register bank (Status/Cause/EPC, plus Count/Compare when CP0_TIMER_EN is defined).
// Latency: combinational reads, single-cycle register updates.
// Backpressure: none; never stalls the controller.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr
`ifdef CP0_TIMER_EN
    ,
    output logic        timer_irq
`endif
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count_val, compare_val;
    logic        ti;
    logic        wr_en;

    // exception and eret both outrank mtc0.
    assign wr_en = mtc0 & ~exception & ~eret;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr_en && (rd == CP0_REG_COUNT)),
        .wr_compare (wr_en && (rd == CP0_REG_COMPARE)),
        .wdata      (wdata),
        .count      (count_val),
        .compare    (compare_val),
        .irq        (ti)
    );
    assign timer_irq = ti;
`else
    assign count_val   = 32'd0;
    assign compare_val = 32'd0;
    assign ti          = 1'b0;
`endif

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (exception) begin
            epc_d        = pc;
            status_d     = {status_q[26:0], 5'b0};
            cause_d[6:2] = cause;
        end else if (eret) begin
            status_d = {5'b0, status_q[31:5]};
        end else if (mtc0) begin
            case (rd)
                CP0_REG_STATUS: status_d = wdata;
                CP0_REG_CAUSE:  cause_d  = wdata & ~CAUSE_TI_MASK;
                CP0_REG_EPC:    epc_d    = wdata;
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (mfc0) begin
            case (rd)
                CP0_REG_COUNT:   rdata = count_val;
                CP0_REG_COMPARE: rdata = compare_val;
                CP0_REG_STATUS:  rdata = status_q;
                CP0_REG_CAUSE:   rdata = cause_q | (ti ? CAUSE_TI_MASK : 32'd0);
                CP0_REG_EPC:     rdata = epc_q;
                default:         rdata = 32'd0;
            endcase
        end
    end

    assign status   = status_q;
    assign exc_addr = eret ? epc_q : CP0_HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Randomized and directed bench for cp0_unit against an architectural register model.
// Set CP0_TIMER_EN to also exercise the Count/Compare timer.
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset, mfc0, mtc0, exception, eret;
    logic [31:0] pc, wdata;
    logic [4:0]  rd, cause;
    logic [31:0] rdata, status, exc_addr;
`ifdef CP0_TIMER_EN
    logic        timer_irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Architectural view of CP0 as software sees it.
    logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
    logic        m_irq;
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk       (clk),
        .reset     (reset),
        .mfc0      (mfc0),
        .mtc0      (mtc0),
        .pc        (pc),
        .rd        (rd),
        .wdata     (wdata),
        .exception (exception),
        .eret      (eret),
        .cause     (cause),
        .rdata     (rdata),
        .status    (status),
        .exc_addr  (exc_addr)
`ifdef CP0_TIMER_EN
        ,
        .timer_irq (timer_irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rdata();
        logic [31:0] v;
        v = 32'd0;
        if (mfc0) begin
            if (rd == 5'd12) v = m_status;
            else if (rd == 5'd13) v = m_cause | (m_irq ? 32'h0000_8000 : 32'd0);
            else if (rd == 5'd14) v = m_epc;
`ifdef CP0_TIMER_EN
            else if (rd == 5'd9) v = m_count;
            else if (rd == 5'd11) v = m_compare;
`endif
        end
        return v;
    endfunction

    task automatic model_edge();
        logic mt;
        if (reset) begin
            m_status = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_irq = 0;
            m_valid = 1'b1;
            return;
        end
        mt = mtc0 && !exception && !eret;
`ifdef CP0_TIMER_EN
        if (mt && rd == 5'd11) m_irq = 0;
        else if (m_count == m_compare && m_compare != 0) m_irq = 1;
        m_count = (mt && rd == 5'd9) ? wdata : m_count + 1;
        if (mt && rd == 5'd11) m_compare = wdata;
`endif
        if (exception) begin
            m_epc = pc;
            m_status = m_status << 5;
            m_cause[6:2] = cause;
        end else if (eret) begin
            m_status = m_status >> 5;
        end else if (mt) begin
            if (rd == 5'd12) m_status = wdata;
            else if (rd == 5'd13) m_cause = wdata & 32'hFFFF_7FFF;
            else if (rd == 5'd14) m_epc = wdata;
        end
    endtask

    task automatic drive(input logic r, input logic mf, input logic mt, input logic ex,
                         input logic er, input logic [4:0] rdv, input logic [31:0] wd,
                         input logic [31:0] pcv, input logic [4:0] cs);
        reset = r; mfc0 = mf; mtc0 = mt; exception = ex; eret = er;
        rd = rdv; wdata = wd; pc = pcv; cause = cs;
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            chk("rdata", rdata, exp_rdata());
            chk("exc_addr", exc_addr, eret ? m_epc : 32'h0040_0004);
            chk("status", status, m_status);
`ifdef CP0_TIMER_EN
            chk("timer_irq", {31'd0, timer_irq}, {31'd0, m_irq});
`endif
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic peek(input logic [4:0] rdv, input logic [31:0] exp, input string tag);
        drive(0, 1, 0, 0, 0, rdv, 32'd0, 32'd0, 5'd0);
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] rsel;
        drive(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clk); #1;
        tick();
        tick();

        drive(0, 1, 0, 0, 0, 5'd12, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t1_rdata", rdata, 32'd0);
        chk("t1_exc_addr", exc_addr, 32'h0040_0004);
        tick();

        drive(0, 0, 1, 0, 0, 5'd12, 32'h0000_001F, 32'd0, 5'd0);
        tick();
        drive(0, 0, 0, 1, 0, 5'd0, 32'd0, 32'h0040_0100, 5'b01000);
        tick();
        chk("t2_status", status, 32'h0000_03E0);
        peek(5'd14, 32'h0040_0100, "t2_epc");
        peek(5'd13, 32'h0000_0020, "t2_cause");

        drive(0, 0, 0, 0, 1, 5'd0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("t3_exc_addr", exc_addr, 32'h0040_0100);
        tick();
        chk("t3_status", status, 32'h0000_001F);

        drive(0, 0, 1, 1, 1, 5'd14, 32'h1234_5678, 32'h0040_0200, 5'b01001);
        tick();
        chk("t4_status", status, 32'h0000_03E0);
        peek(5'd14, 32'h0040_0200, "t4_epc");
        peek(5'd13, 32'h0000_0024, "t4_cause");

        drive(0, 1, 1, 0, 0, 5'd14, 32'hCAFE_F00D, 32'd0, 5'd0);
        #1;
        chk("t5_old_epc", rdata, 32'h0040_0200);
        tick();
        peek(5'd14, 32'hCAFE_F00D, "t5_new_epc");

`ifdef CP0_TIMER_EN
        begin
            bit found;
            int n;
            found = 0;
            n = 0;
            drive(1, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0);
            tick();
            drive(0, 0, 1, 0, 0, 5'd11, 32'd10, 32'd0, 5'd0);
            tick();
            drive(0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 5'd0);
            for (int i = 0; i < 30 && !found; i++) begin
                tick();
                n++;
                if (timer_irq) found = 1;
            end
            chk("t6_irq_seen", {31'd0, found}, 32'd1);
            chk("t6_irq_cycle", n, 10);
            peek(5'd13, 32'h0000_8000, "t6_cause_ti");
            drive(0, 0, 1, 0, 0, 5'd11, 32'd0, 32'd0, 5'd0);
            tick();
            chk("t6_irq_clr", {31'd0, timer_irq}, 32'd0);
            drive(1, 0, 1, 0, 0, 5'd12, 32'hFFFF_FFFF, 32'd0, 5'd0);
            tick();
            peek(5'd12, 32'd0, "t6_rst_status");
            peek(5'd13, 32'd0, "t6_rst_cause");
            peek(5'd14, 32'd0, "t6_rst_epc");
            peek(5'd9, 32'd0, "t6_rst_count");
            peek(5'd11, 32'd0, "t6_rst_compare");
            chk("t6_rst_irq", {31'd0, timer_irq}, 32'd0);
            drive(0, 0, 1, 0, 0, 5'd9, 32'hFFFF_FFFF, 32'd0, 5'd0);
            tick();
            peek(5'd9, 32'hFFFF_FFFF, "t7_count_max");
            tick();
            peek(5'd9, 32'd0, "t7_count_wrap");
        end
`else
        drive(0, 0, 1, 0, 0, 5'd9, 32'h0000_0055, 32'd0, 5'd0);
        tick();
        drive(0, 0, 1, 0, 0, 5'd11, 32'h0000_0066, 32'd0, 5'd0);
        tick();
        peek(5'd9, 32'd0, "nt_count");
        peek(5'd11, 32'd0, "nt_compare");
        drive(0, 0, 1, 0, 0, 5'd13, 32'hFFFF_FFFF, 32'd0, 5'd0);
        tick();
        peek(5'd13, 32'hFFFF_7FFF, "nt_cause_b15");
`endif

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: rsel = 5'd9;
                1: rsel = 5'd11;
                2: rsel = 5'd12;
                3: rsel = 5'd13;
                4: rsel = 5'd14;
                default: rsel = 5'($urandom);
            endcase
            drive($urandom_range(0, 60) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  rsel,
                  ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 48)) : $urandom,
                  $urandom,
                  5'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
